// File: rtl/sobel_filter.sv
// Sobel edge magnitude (|Gx|+|Gy|, saturated to 8 bits) over a raster pixel stream.
// Latency: result for the window completed by pixel n is registered on the edge accepting pixel n+1.
// Backpressure: none; one pixel is accepted on every rising edge while out of reset.
module sobel_filter #(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_data,
    output logic [7:0] edge_pixel,
    output logic       edge_valid
);

    localparam int AW   = $clog2(IMG_WIDTH);
    localparam int FULL = 2 * IMG_WIDTH + 2;
    localparam int CW   = $clog2(FULL + 1);

    generate
        if (IMG_WIDTH < 4 || IMG_WIDTH > 1024 || IMG_HEIGHT < 1) begin : g_bad_param
            $error("sobel_filter: IMG_WIDTH must be 4..1024 and IMG_HEIGHT positive");
        end
    endgenerate

    // Line memories are never cleared; the fill counter keeps stale data off the output.
    logic [7:0]    line1 [IMG_WIDTH];
    logic [7:0]    line2 [IMG_WIDTH];
    logic [AW-1:0] wr_ptr;
    logic [7:0]    tap1;
    logic [7:0]    tap2;

    assign tap1 = line1[wr_ptr];
    assign tap2 = line2[wr_ptr];

    always_ff @(posedge clk) begin
        line1[wr_ptr] <= pixel_data;
        line2[wr_ptr] <= tap1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
        end else if (wr_ptr == AW'(IMG_WIDTH - 1)) begin
            wr_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // win[r][c]: r=0 oldest line, c=0 oldest column
    logic [7:0] win [3][3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[2][2] <= pixel_data;
            win[1][2] <= tap1;
            win[0][2] <= tap2;
        end
    end

    // Counter stops at FULL, so win_full stays high for arbitrarily long streams.
    logic [CW-1:0] pix_cnt;
    logic          win_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt  <= '0;
            win_full <= 1'b0;
        end else begin
            if (pix_cnt != CW'(FULL)) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            win_full <= (pix_cnt == CW'(FULL));
        end
    end

    function automatic logic signed [11:0] ext(input logic [7:0] p);
        return $signed({4'b0000, p});
    endfunction

    logic signed [11:0] gx;
    logic signed [11:0] gy;
    logic        [11:0] abs_gx;
    logic        [11:0] abs_gy;
    logic        [11:0] mag;
    logic        [7:0]  mag_sat;

    always_comb begin
        gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
        gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
        abs_gx  = gx[11] ? 12'(-gx) : 12'(gx);
        abs_gy  = gy[11] ? 12'(-gy) : 12'(gy);
        mag     = abs_gx + abs_gy;
        mag_sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_pixel <= '0;
            edge_valid <= 1'b0;
        end else begin
            edge_valid <= win_full;
            edge_pixel <= win_full ? mag_sat : 8'h00;
        end
    end

endmodule

// File: tb/tb_sobel_filter.sv
// Directed bench for sobel_filter: uniform, ramp, step, single-dot images and mid-stream reset.
module tb_sobel_filter;

    localparam int W = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pixel_data = 8'd0;
    logic [7:0] edge_pixel;
    logic       edge_valid;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    always #5 clk = ~clk;

    sobel_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_data (pixel_data),
        .edge_pixel (edge_pixel),
        .edge_valid (edge_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d k=%0d", tag, obs, exp, k);
        end
    endtask

    // mode: 0 uniform 100, 1 ramp, 2 vertical step, 3 horizontal step, 4 white with one black dot
    function automatic logic [7:0] pix_of(input int mode, input int n);
        int col = n % W;
        int row = n / W;
        case (mode)
            0: return 8'd100;
            1: return 8'(col);
            2: return (col < 64) ? 8'd0 : 8'd255;
            3: return (row < 64) ? 8'd0 : 8'd10;
            default: return (n == 10 * W + 50) ? 8'd0 : 8'd255;
        endcase
    endfunction

    // Expected magnitude for the window whose newest pixel is m; -1 means row-wrap window, unchecked.
    function automatic int exp_of(input int mode, input int m);
        int col = m % W;
        int row = m / W;
        bit wrap = (col < 2);
        case (mode)
            0: return 0;
            1: return wrap ? -1 : 8;
            2: return wrap ? -1 : ((col == 64 || col == 65) ? 255 : 0);
            3: return wrap ? -1 : ((row == 64 || row == 65) ? 40 : 0);
            default: begin
                if (row >= 10 && row <= 12 && col >= 50 && col <= 52)
                    return (row == 11 && col == 51) ? 0 : 255;
                return 0;
            end
        endcase
    endfunction

    task automatic run(input int mode, input int npix, input string tag);
        for (int i = 0; i < npix; i++) begin
            int m;
            int e;
            bit ev;
            pixel_data = pix_of(mode, k);
            @(posedge clk);
            #1;
            k++;
            m  = k - 2;
            ev = (m >= 2 * W + 2);
            chk({tag, "_valid"}, 32'(edge_valid), 32'(ev));
            if (!ev) begin
                chk({tag, "_idle_zero"}, 32'(edge_pixel), 32'd0);
            end else begin
                e = exp_of(mode, m);
                if (e >= 0) chk({tag, "_pixel"}, 32'(edge_pixel), 32'(e));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        k   = 0;
    endtask

    initial begin
        #2;
        rst = 1'b0;
        #1;
        chk("reset_async_valid", 32'(edge_valid), 32'd0);
        chk("reset_async_pixel", 32'(edge_pixel), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held_valid", 32'(edge_valid), 32'd0);
        chk("reset_held_pixel", 32'(edge_pixel), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        k   = 0;

        run(0, 300, "uniform");

        do_reset();
        run(1, 3 * W + 20, "ramp");

        do_reset();
        run(2, 3 * W + 20, "vstep");

        do_reset();
        run(3, 68 * W, "hstep");

        do_reset();
        run(4, 14 * W, "dot");

        do_reset();
        run(1, 5000, "pre_reset");
        chk("pre_reset_pixel", 32'(edge_pixel), 32'd8);
        rst = 1'b0;
        #1;
        chk("midreset_async_valid", 32'(edge_valid), 32'd0);
        chk("midreset_async_pixel", 32'(edge_pixel), 32'd0);
        @(posedge clk);
        #1;
        chk("midreset_held_valid", 32'(edge_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        k   = 0;
        run(1, 2 * W + 40, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
